// File: rtl/m_serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings, default width
// and the full-subtractor bit equations.
package m_serial_sub_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic fs_diff(input logic a, input logic b, input logic bin);
      return a ^ b ^ bin;
   endfunction

   // Borrow out: a<b outright, or a==b with a pending borrow.
   function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
      return (~a & b) | (~(a ^ b) & bin);
   endfunction

endpackage

// File: rtl/m_FS.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow out.
module m_FS
   import m_serial_sub_pkg::*;
(
   input  logic w_a,
   input  logic w_b,
   input  logic w_bin,
   output logic w_d,
   output logic w_bo
);

   assign w_d  = fs_diff(w_a, w_b, w_bin);
   assign w_bo = fs_borrow(w_a, w_b, w_bin);

endmodule

// File: rtl/m_serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell and a
// registered borrow; parallel load under a start/done handshake.
module m_serial_sub
   import m_serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             w_clk,
   input  logic             w_rst,
   input  logic             w_start,
   input  logic [WIDTH-1:0] w_a,
   input  logic [WIDTH-1:0] w_b,
   output logic             r_busy,
   output logic             r_done,
   output logic [WIDTH-1:0] r_d,
   output logic             r_bout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic             r_borrow;
   logic [CNT_W-1:0] r_cnt;
   logic             w_d;
   logic             w_bo;

   m_FS u_fs (
      .w_a   (r_sa[0]),
      .w_b   (r_sb[0]),
      .w_bin (r_borrow),
      .w_d   (w_d),
      .w_bo  (w_bo)
   );

   // Control FSM and serial datapath; outputs are written only here.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_state  <= S_IDLE;
         r_sa     <= '0;
         r_sb     <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_d      <= '0;
         r_bout   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_sa     <= w_a;
                  r_sb     <= w_b;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
               end else begin
                  r_state  <= S_IDLE;
               end
            end
            S_RUN: begin
               r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
               r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
               r_d      <= {w_d, r_d[WIDTH-1:1]};
               r_bout   <= w_bo;
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (r_cnt == C_LAST) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
